// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath: register indices, status flag bit positions and reset defaults.
// The register-select mux uses the same index constants, so bank and mux always agree on the encoding.
package cpu_pkg;

    localparam int REG_WIDTH = 8;
    localparam int SEL_WIDTH = 4;
    localparam int NUM_REGS  = 8;

    localparam logic [SEL_WIDTH-1:0] REG_A   = 4'd0;
    localparam logic [SEL_WIDTH-1:0] REG_X   = 4'd1;
    localparam logic [SEL_WIDTH-1:0] REG_Y   = 4'd2;
    localparam logic [SEL_WIDTH-1:0] REG_SP  = 4'd3;
    localparam logic [SEL_WIDTH-1:0] REG_P   = 4'd4;
    localparam logic [SEL_WIDTH-1:0] REG_PCL = 4'd5;
    localparam logic [SEL_WIDTH-1:0] REG_PCH = 4'd6;
    localparam logic [SEL_WIDTH-1:0] REG_TMP = 4'd7;

    localparam int FLAG_N   = 7;
    localparam int FLAG_V   = 6;
    localparam int FLAG_ONE = 5;
    localparam int FLAG_B   = 4;
    localparam int FLAG_D   = 3;
    localparam int FLAG_I   = 2;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_C   = 0;

    localparam logic [REG_WIDTH-1:0] SP_RESET_VAL = 8'hFD;
    localparam logic [REG_WIDTH-1:0] P_RESET_VAL  = 8'h34;

    // One-hot write decode; selector values 8-15 decode to nothing.
    function automatic logic [NUM_REGS-1:0] sel_decode(input logic en, input logic [SEL_WIDTH-1:0] sel);
        logic [NUM_REGS-1:0] hot;
        hot = '0;
        if (en && !sel[SEL_WIDTH-1])
            hot[sel[2:0]] = 1'b1;
        return hot;
    endfunction

    function automatic logic is_index_reg(input logic [SEL_WIDTH-1:0] sel);
        return (sel == REG_A) || (sel == REG_X) || (sel == REG_Y);
    endfunction

endpackage

// File: rtl/pc_counter.sv
// 16-bit program counter built from two byte registers; byte loads take priority over increment.
// Latency one edge; no backpressure, a load or increment is accepted every cycle.
module pc_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_lo,
    input  logic         ld_hi,
    input  logic         inc,
    input  logic [W-1:0] ld_data,
    output logic [W-1:0] pcl,
    output logic [W-1:0] pch
);

    logic [2*W-1:0] pc_q;
    logic [2*W-1:0] pc_plus_one;

    assign pc_plus_one = pc_q + (2*W)'(1);

    // A load of either byte freezes the whole pair, so the untouched byte holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (ld_lo || ld_hi) begin
            if (ld_lo)
                pc_q[W-1:0] <= ld_data;
            if (ld_hi)
                pc_q[2*W-1:W] <= ld_data;
        end else if (inc) begin
            pc_q <= pc_plus_one;
        end
    end

    assign pcl = pc_q[W-1:0];
    assign pch = pc_q[2*W-1:W];

endmodule

// File: rtl/cpu_reg_bank.sv
// Architectural register bank (A, X, Y, SP, P, PCL, PCH, TMP) with PC increment, SP stepping and flag updates.
// Latency one edge, no write bypass; no backpressure, one bus write plus steps accepted every cycle.
module cpu_reg_bank
    import cpu_pkg::*;
#(
    parameter int                     SIGNAL_WIDTH   = REG_WIDTH,
    parameter int                     SELECTOR_WIDTH = SEL_WIDTH,
    parameter logic [SIGNAL_WIDTH-1:0] SP_RESET      = SP_RESET_VAL,
    parameter logic [SIGNAL_WIDTH-1:0] P_RESET       = P_RESET_VAL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [SELECTOR_WIDTH-1:0] wr_sel,
    input  logic [SIGNAL_WIDTH-1:0]   wr_data,
    input  logic                      nz_en,
    input  logic                      c_we,
    input  logic                      c_in,
    input  logic                      v_we,
    input  logic                      v_in,
    input  logic                      pc_inc,
    input  logic                      sp_inc,
    input  logic                      sp_dec,
    output logic [SIGNAL_WIDTH-1:0]   reg_a,
    output logic [SIGNAL_WIDTH-1:0]   reg_x,
    output logic [SIGNAL_WIDTH-1:0]   reg_y,
    output logic [SIGNAL_WIDTH-1:0]   reg_sp,
    output logic [SIGNAL_WIDTH-1:0]   reg_p,
    output logic [SIGNAL_WIDTH-1:0]   reg_pcl,
    output logic [SIGNAL_WIDTH-1:0]   reg_pch,
    output logic [SIGNAL_WIDTH-1:0]   reg_tmp
);

    logic [NUM_REGS-1:0]     wr_hot;
    logic                    nz_upd;
    logic [SIGNAL_WIDTH-1:0] sp_nxt;
    logic [SIGNAL_WIDTH-1:0] p_nxt;

    assign wr_hot = sel_decode(wr_en, SEL_WIDTH'(wr_sel));
    assign nz_upd = wr_en && nz_en && is_index_reg(SEL_WIDTH'(wr_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a   <= '0;
            reg_x   <= '0;
            reg_y   <= '0;
            reg_tmp <= '0;
        end else begin
            if (wr_hot[REG_A])
                reg_a <= wr_data;
            if (wr_hot[REG_X])
                reg_x <= wr_data;
            if (wr_hot[REG_Y])
                reg_y <= wr_data;
            if (wr_hot[REG_TMP])
                reg_tmp <= wr_data;
        end
    end

    always_comb begin
        sp_nxt = reg_sp;
        if (wr_hot[REG_SP]) begin
            sp_nxt = wr_data;
        end else begin
            unique case ({sp_inc, sp_dec})
                2'b10:   sp_nxt = reg_sp + SIGNAL_WIDTH'(1);
                2'b01:   sp_nxt = reg_sp - SIGNAL_WIDTH'(1);
                default: sp_nxt = reg_sp;
            endcase
        end
    end

    // A direct write to P overrides every flag update; bit 5 is hard-wired to 1.
    always_comb begin
        p_nxt = reg_p;
        if (wr_hot[REG_P]) begin
            p_nxt = wr_data;
        end else begin
            if (nz_upd) begin
                p_nxt[FLAG_N] = wr_data[SIGNAL_WIDTH-1];
                p_nxt[FLAG_Z] = (wr_data == '0);
            end
            if (c_we)
                p_nxt[FLAG_C] = c_in;
            if (v_we)
                p_nxt[FLAG_V] = v_in;
        end
        p_nxt[FLAG_ONE] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_sp <= SP_RESET;
            reg_p  <= P_RESET;
        end else begin
            reg_sp <= sp_nxt;
            reg_p  <= p_nxt;
        end
    end

    pc_counter #(
        .W(SIGNAL_WIDTH)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_lo   (wr_hot[REG_PCL]),
        .ld_hi   (wr_hot[REG_PCH]),
        .inc     (pc_inc),
        .ld_data (wr_data),
        .pcl     (reg_pcl),
        .pch     (reg_pch)
    );

endmodule

// File: doc/cpu_reg_bank.md
Name: cpu_reg_bank

Overview:
- Architectural register bank of the 6502-compatible CPU core (A, X, Y, SP, P, PCL, PCH, TMP).
- Sits directly upstream of the 16:1 register-select mux; its eight register outputs drive mux inputs 0-7.
- Accepts one bus write per cycle using the same 4-bit selector encoding as the mux.
- Also provides PC increment, SP push/pop stepping and ALU flag updates.

Parameters:
- SIGNAL_WIDTH, `REG_WIDTH (8): width of every register and of the write data.
- SELECTOR_WIDTH, 4: width of wr_sel; must match the mux selector.
- SP_RESET, 8'hFD: stack pointer value after reset.
- P_RESET, 8'h34: status register value after reset (I=1, bit5=1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  bus write strobe.
- wr_sel  in  SELECTOR_WIDTH  destination register; same encoding as the mux.
- wr_data  in  SIGNAL_WIDTH  write data.
- nz_en  in  1  update N/Z flags from wr_data when the write targets A, X or Y.
- c_we  in  1  load carry flag.
- c_in  in  1  carry value from the ALU.
- v_we  in  1  load overflow flag.
- v_in  in  1  overflow value from the ALU.
- pc_inc  in  1  increment the 16-bit {PCH,PCL}.
- sp_inc  in  1  increment SP (pull).
- sp_dec  in  1  decrement SP (push).
- reg_a, reg_x, reg_y, reg_sp, reg_p, reg_pcl, reg_pch, reg_tmp  out  SIGNAL_WIDTH each  registered outputs feeding mux in0-in7.

Behaviour:
- Reset: async, active-low, on rst_n fall; held while low. Values during reset: A=X=Y=TMP=PCL=PCH=0, SP=SP_RESET, P=P_RESET.
- Select encoding: 0=A, 1=X, 2=Y, 3=SP, 4=P, 5=PCL, 6=PCH, 7=TMP. Selector values 8-15 are unmapped; writes to them are ignored with no state change.
- Latency: a write or step takes effect on the next rising edge and is visible on outputs that same edge. In the cycle of the write, outputs still show the old value; there is no bypass.
- P bit layout: N=7, V=6, 1=5, B=4, D=3, I=2, Z=1, C=0. Bit 5 always reads 1, including after a direct write of 0.
- NZ update: when wr_en & nz_en & wr_sel in {0,1,2}, then N=wr_data[7] and Z=(wr_data==0). nz_en is ignored for any other destination.
- c_we / v_we: load C / V from c_in / v_in.
- PC increment: {PCH,PCL}+1, 16-bit, wrapping FFFF->0000. Carry from PCL propagates into PCH in the same edge.
- SP stepping: 8-bit wrap (00-1 -> FF, FF+1 -> 00). sp_inc & sp_dec together: SP unchanged.
- Priority:
  - A direct write to PCL or PCH beats pc_inc for the whole PC pair; no increment that cycle, and the other byte holds.
  - A direct write to SP beats sp_inc/sp_dec.
  - A direct write to P beats nz/c/v updates in the same cycle.
  - nz, c and v updates to different bits combine freely.
- Reset mid-operation: all pending writes and steps are discarded; outputs return to their reset values immediately.

Decomposition:
- Shared package (cpu_pkg):
  - register index constants REG_A..REG_TMP, 4'd0..4'd7;
  - flag bit positions FLAG_N..FLAG_C;
  - SP_RESET and P_RESET defaults.
- The mux uses the same index constants.
- Sub-module pc_counter: 16-bit PC pair with byte loads, increment and load-over-increment priority.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> outputs immediately A=00, SP=FD, P=34, PC=0000. Writes issued while rst_n is low are ignored.
- Write A=80 with nz_en -> next edge reg_a=80, P=B4 (N=1, Z=0). Then write X=00 with nz_en -> P=36 (N=0, Z=1).
- PC wrap: write PCL=FF and PCH=FF, then pc_inc -> PC=0000. Write PCL=10 with pc_inc in the same cycle -> PCL=10, PCH unchanged.
- SP:
  - from FD, sp_dec x3 -> FA;
  - from 00, sp_dec -> FF;
  - sp_inc & sp_dec together -> unchanged;
  - write SP=40 with sp_inc -> 40.
- Write P=00 -> reg_p=20. In the same cycle assert c_we with c_in=1 -> P=20 (direct write wins).
- Write wr_sel=9, data=AA -> no output changes. Write TMP=5A -> reg_tmp=5A, P unchanged even with nz_en=1.
